// File: rtl/fpga_top_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_top_pkg
// Description : Shared types and constants for the fpga_top bring-up block.
//               Output source select encoding, rotator reset pattern and
//               the default prescaler ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_top_pkg;

    // Output source select, taken from the two LSBs of the synchronized pins.
    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_EVENTS = 2'd3
    } mode_e;

    localparam logic [7:0] ROT_RESET        = 8'h01;
    localparam int         TICK_DIV_DEFAULT = 16;

endpackage : fpga_top_pkg
`default_nettype wire

// File: rtl/fpga_top_io_sync.sv
`default_nettype none
// ============================================================================
// Module      : io_sync
// Description : Two-flop synchronizer for a bus of independent asynchronous
//               bits. Each bit is synchronized on its own; no coherence
//               between bits is implied.
// Ports       : clk   - destination clock
//               rst   - asynchronous active-low reset (flops clear to 0)
//               d     - asynchronous input bits
//               q     - synchronized output bits
// Revision    : 1.0 - initial release
// ============================================================================
module io_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : io_sync
`default_nettype wire

// File: rtl/fpga_top.sv
`default_nettype none
// ============================================================================
// Module      : fpga_top
// Description : FPGA bring-up top. Synchronizes eight input pins and drives
//               eight registered output pins from one of four sources chosen
//               by sync_in[1:0]: passthrough, tick counter, one-hot rotator,
//               or rising-edge count of sync_in[7]. All sources run all the
//               time; the mode only steers the output mux.
// Ports       : clk         - sole clock, rising edge
//               rst         - asynchronous active-low reset
//               input_pins  - asynchronous pins ([1:0] mode, [7] event)
//               output_pins - registered output pins
// Params      : TICK_DIV    - prescaler ratio (>= 2); one tick per TICK_DIV clks
// Macros      : FPGA_TOP_HEARTBEAT_EN - when defined, output_pins[7] carries a
//               heartbeat that toggles on every tick, in every mode.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_top
    import fpga_top_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] input_pins,
    output logic [7:0] output_pins
);

    localparam int                  PRESC_W   = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [7:0]         w_sync_in;
    mode_e              w_mode;
    logic               w_tick;
    logic               w_event;
    logic [7:0]         w_mux;
    logic [7:0]         w_out_next;

    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_count;
    logic [7:0]         r_rot;
    logic               r_evt_dly;
    logic [7:0]         r_events;
    logic [7:0]         r_out;

    io_sync #(
        .WIDTH (8)
    ) u_io_sync (
        .clk (clk),
        .rst (rst),
        .d   (input_pins),
        .q   (w_sync_in)
    );

    assign w_mode  = mode_e'(w_sync_in[1:0]);
    assign w_tick  = (r_presc == PRESC_MAX);
    assign w_event = w_sync_in[7] & ~r_evt_dly;

    // Prescaler: free-running 0..TICK_DIV-1, tick on the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Tick-driven sources. Both advance regardless of the selected mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'h00;
            r_rot   <= ROT_RESET;
        end else if (w_tick) begin
            r_count <= r_count + 8'h01;
            r_rot   <= {r_rot[6:0], r_rot[7]};
        end
    end

    // Rising-edge counter on the synchronized event bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_dly <= 1'b0;
            r_events  <= 8'h00;
        end else begin
            r_evt_dly <= w_sync_in[7];
            if (w_event) begin
                r_events <= r_events + 8'h01;
            end
        end
    end

    always_comb begin
        w_mux = w_sync_in;
        case (w_mode)
            MODE_PASS:   w_mux = w_sync_in;
            MODE_COUNT:  w_mux = r_count;
            MODE_ROTATE: w_mux = r_rot;
            MODE_EVENTS: w_mux = r_events;
            default:     w_mux = w_sync_in;
        endcase
    end

`ifdef FPGA_TOP_HEARTBEAT_EN
    logic r_heartbeat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_heartbeat <= 1'b0;
        end else if (w_tick) begin
            r_heartbeat <= ~r_heartbeat;
        end
    end

    // Heartbeat owns bit 7 in every mode; it goes through the same output
    // register so its latency matches the other bits.
    assign w_out_next = {r_heartbeat, w_mux[6:0]};
`else
    assign w_out_next = w_mux;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= 8'h00;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign output_pins = r_out;

endmodule : fpga_top
`default_nettype wire

// File: tb/tb_fpga_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_top
// Description : Self-checking bench for fpga_top (TICK_DIV = 16). Expected
//               output values are derived from the cycle number since reset
//               release and queued with the cycle at which they are due; each
//               test drains the queue at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_top;

    localparam int TDIV = 16;

    logic       clk;
    logic       rst;
    logic [7:0] input_pins;
    logic [7:0] output_pins;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];

    fpga_top #(
        .TICK_DIV (TDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_pins  (input_pins),
        .output_pins (output_pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release: after the k-th edge, cyc == k.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // With the heartbeat build, bit 7 seen after edge k is the heartbeat
    // as it stood after edge k-1: it toggles once per TDIV cycles.
    function automatic logic [7:0] hb_fix(input logic [7:0] v, input int k);
        logic [7:0] r;
        r = v;
`ifdef FPGA_TOP_HEARTBEAT_EN
        r[7] = (((k - 1) / TDIV) % 2) == 1;
`endif
        return r;
    endfunction

    task automatic push(input int k, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = k;
        e.val  = hb_fix(v, k);
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic apply_reset(input logic [7:0] pins);
        @(negedge clk);
        rst        = 1'b0;
        input_pins = pins;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        exp_t e;
        rst        = 1'b0;
        input_pins = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (output_pins !== 8'h00)
                $display("FAIL reset_hold got=%h exp=00", output_pins);
            else
                n_pass++;
        end
        rst = 1'b1;
        // A5 selects COUNT with the counter still at zero.
        for (int k = 1; k <= 7; k++) push(k, 8'h00, "reset_count0");
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (output_pins !== e.val)
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, output_pins, e.val);
                else
                    n_pass++;
            end
            if (cyc == 5) begin
                input_pins = 8'hA4;
                push(cyc + 3, 8'hA4, "reset_pass_a4");
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL reset_leftover pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_count;
        exp_t e;
        apply_reset(8'h01);
        push(3,    8'h00, "count_start");
        push(16,   8'h00, "count_pre_tick");
        push(17,   8'h01, "count_first_tick");
        push(67,   8'h04, "count_64cyc");
        push(4096, 8'hFF, "count_ff");
        push(4097, 8'h00, "count_wrap");
        for (int t = 0; t < 4100; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (output_pins !== e.val)
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, output_pins, e.val);
                else
                    n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL count_leftover pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_rotate;
        exp_t       e;
        logic [7:0] v;
        apply_reset(8'h02);
        v = 8'h01;
        push(3, v, "rotate_start");
        for (int j = 1; j <= 9; j++) begin
            push(TDIV * j, v, "rotate_hold");
            v = {v[6:0], v[7]};
            push(TDIV * j + 1, v, "rotate_step");
        end
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (output_pins !== e.val)
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, output_pins, e.val);
                else
                    n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL rotate_leftover pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_events;
        exp_t e;
        logic b7;
        int   p;
        int   n;
        apply_reset(8'h03);
        push(4, 8'h00, "events_idle");
        // 256 pulses, 3 cycles high / 3 low, starting at cycle 5.
        for (int t = 0; t < 1560; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (output_pins !== e.val)
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, output_pins, e.val);
                else
                    n_pass++;
            end
            p  = cyc - 5;
            b7 = 1'b0;
            if (p >= 0 && p < 256 * 6) begin
                b7 = (p % 6) < 3;
                if (p % 6 == 0) begin
                    n = p / 6 + 1;
                    push(cyc + 3, 8'(n - 1), "events_before");
                    push(cyc + 4, 8'(n),     "events_after");
                end
            end
            input_pins = {b7, 7'b0000011};
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL events_leftover pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mode_switch;
        exp_t e;
        apply_reset(8'h01);
        push(260, 8'h10, "switch_count10");
        push(262, 8'h10, "switch_count_still");
        push(263, 8'h04, "switch_pass");
        push(300, 8'h04, "switch_pass_hold");
        push(362, 8'h04, "switch_pass_last");
        push(363, 8'h16, "switch_count_resumed");
        push(400, 8'h18, "switch_count_later");
        for (int t = 0; t < 410; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (output_pins !== e.val)
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, output_pins, e.val);
                else
                    n_pass++;
            end
            if (cyc == 260) input_pins = 8'h04;
            if (cyc == 360) input_pins = 8'h01;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL switch_leftover pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_heartbeat;
        exp_t e;
        apply_reset(8'h00);
        for (int k = 2; k <= 70; k++) push(k, 8'h00, "heartbeat_pass0");
        for (int t = 0; t < 72; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (output_pins !== e.val)
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, output_pins, e.val);
                else
                    n_pass++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL heartbeat_leftover pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst        = 1'b0;
        input_pins = 8'h00;
        test_reset();
        test_count();
        test_rotate();
        test_events();
        test_mode_switch();
        test_heartbeat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fpga_top
`default_nettype wire
